// File: rtl/game_timer_ctrl.sv
// Round sequencer between the game FSM and the stopwatch: issues start/pause/stop
// pulses, enforces the round time limit, and keeps final and best winning times.
module game_timer_ctrl #(
    parameter int unsigned TIME_LIMIT_S = 600,
    parameter int unsigned HOLDOFF      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_start,
    input  logic       pause_req,
    input  logic       game_won,
    input  logic       abort,
    input  logic       clear_best,
    input  logic [5:0] sw_minutes,
    input  logic [5:0] sw_seconds,
    output logic       sw_start,
    output logic       sw_pause,
    output logic       sw_stop,
    output logic [1:0] state_out,
    output logic [1:0] result,
    output logic [5:0] final_min,
    output logic [5:0] final_sec,
    output logic [5:0] best_min,
    output logic [5:0] best_sec,
    output logic       best_valid,
    output logic       new_record
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUNNING  = 2'b01,
        PAUSED   = 2'b10,
        FINISHED = 2'b11
    } state_t;

    localparam int unsigned HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [11:0] LIMIT = 12'(TIME_LIMIT_S);

    state_t        state_q;
    logic [HW-1:0] holdoff_q;
    logic          sw_start_q, sw_pause_q, sw_stop_q;
    logic [1:0]    result_q;
    logic [5:0]    final_min_q, final_sec_q, best_min_q, best_sec_q;
    logic          best_valid_q, new_record_q;

    logic [11:0]   elapsed_d, best_elapsed_d;
    logic          timeout_d, record_d;

    assign elapsed_d      = 12'(sw_minutes) * 12'd60 + 12'(sw_seconds);
    assign best_elapsed_d = 12'(best_min_q) * 12'd60 + 12'(best_sec_q);
    assign timeout_d      = (holdoff_q == '0) && (elapsed_d >= LIMIT);
    // A coincident clear_best wipes the old record first, so the win always counts.
    assign record_d       = !best_valid_q || clear_best || (elapsed_d < best_elapsed_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            holdoff_q    <= '0;
            sw_start_q   <= 1'b0;
            sw_pause_q   <= 1'b0;
            sw_stop_q    <= 1'b0;
            result_q     <= 2'b00;
            final_min_q  <= '0;
            final_sec_q  <= '0;
            best_min_q   <= '0;
            best_sec_q   <= '0;
            best_valid_q <= 1'b0;
            new_record_q <= 1'b0;
        end else begin
            sw_start_q <= 1'b0;
            sw_pause_q <= 1'b0;
            sw_stop_q  <= 1'b0;
            if (clear_best) begin
                best_valid_q <= 1'b0;
                best_min_q   <= '0;
                best_sec_q   <= '0;
            end
            case (state_q)
                IDLE, FINISHED: begin
                    if (game_start) begin
                        state_q      <= RUNNING;
                        sw_start_q   <= 1'b1;
                        result_q     <= 2'b00;
                        new_record_q <= 1'b0;
                        final_min_q  <= '0;
                        final_sec_q  <= '0;
                        holdoff_q    <= HW'(HOLDOFF);
                    end
                end
                RUNNING: begin
                    if (holdoff_q != '0)
                        holdoff_q <= holdoff_q - 1'b1;
                    if (abort || game_won || timeout_d) begin
                        state_q     <= FINISHED;
                        sw_stop_q   <= 1'b1;
                        final_min_q <= sw_minutes;
                        final_sec_q <= sw_seconds;
                        if (abort)
                            result_q <= 2'b11;
                        else if (game_won) begin
                            result_q <= 2'b01;
                            if (record_d) begin
                                best_min_q   <= sw_minutes;
                                best_sec_q   <= sw_seconds;
                                best_valid_q <= 1'b1;
                                new_record_q <= 1'b1;
                            end
                        end else
                            result_q <= 2'b10;
                    end else if (pause_req) begin
                        state_q    <= PAUSED;
                        sw_pause_q <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (abort) begin
                        state_q     <= FINISHED;
                        sw_stop_q   <= 1'b1;
                        result_q    <= 2'b11;
                        final_min_q <= sw_minutes;
                        final_sec_q <= sw_seconds;
                    end else if (pause_req) begin
                        state_q    <= RUNNING;
                        sw_start_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sw_start   = sw_start_q;
    assign sw_pause   = sw_pause_q;
    assign sw_stop    = sw_stop_q;
    assign state_out  = state_q;
    assign result     = result_q;
    assign final_min  = final_min_q;
    assign final_sec  = final_sec_q;
    assign best_min   = best_min_q;
    assign best_sec   = best_sec_q;
    assign best_valid = best_valid_q;
    assign new_record = new_record_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl: a default-limit instance and a 5-second-limit
// instance share stimulus; expected output snapshots go through a scoreboard queue.
module tb_game_timer_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic game_start, pause_req, game_won, abort, clear_best;
    logic [5:0] sw_min, sw_sec;

    logic       a_start, a_pause, a_stop, a_bv, a_nr;
    logic [1:0] a_state, a_result;
    logic [5:0] a_fmin, a_fsec, a_bmin, a_bsec;
    logic       b_start, b_pause, b_stop, b_bv, b_nr;
    logic [1:0] b_state, b_result;
    logic [5:0] b_fmin, b_fsec, b_bmin, b_bsec;

    always #5 clk = ~clk;

    game_timer_ctrl dut_a (
        .clk(clk), .rst(rst), .game_start(game_start), .pause_req(pause_req),
        .game_won(game_won), .abort(abort), .clear_best(clear_best),
        .sw_minutes(sw_min), .sw_seconds(sw_sec),
        .sw_start(a_start), .sw_pause(a_pause), .sw_stop(a_stop),
        .state_out(a_state), .result(a_result), .final_min(a_fmin), .final_sec(a_fsec),
        .best_min(a_bmin), .best_sec(a_bsec), .best_valid(a_bv), .new_record(a_nr)
    );

    game_timer_ctrl #(.TIME_LIMIT_S(5), .HOLDOFF(2)) dut_b (
        .clk(clk), .rst(rst), .game_start(game_start), .pause_req(pause_req),
        .game_won(game_won), .abort(abort), .clear_best(clear_best),
        .sw_minutes(sw_min), .sw_seconds(sw_sec),
        .sw_start(b_start), .sw_pause(b_pause), .sw_stop(b_stop),
        .state_out(b_state), .result(b_result), .final_min(b_fmin), .final_sec(b_fsec),
        .best_min(b_bmin), .best_sec(b_bsec), .best_valid(b_bv), .new_record(b_nr)
    );

    // Expected outputs, edited step by step by the directed sequence.
    logic [1:0] e_state, e_result;
    logic [2:0] e_cmd;  // {start, pause, stop}
    logic [5:0] e_fmin, e_fsec, e_bmin, e_bsec;
    logic       e_bv, e_nr;

    typedef struct {
        string       tag;
        logic [32:0] val;
    } exp_t;
    exp_t sb[$];

    int tests_run = 0;
    int tests_failed = 0;

    function automatic logic [32:0] exp_vec();
        return {e_state, e_result, e_cmd, e_fmin, e_fsec, e_bmin, e_bsec, e_bv, e_nr};
    endfunction

    function automatic logic [32:0] obs_vec(input bit use_b);
        if (use_b)
            return {b_state, b_result, b_start, b_pause, b_stop, b_fmin, b_fsec,
                    b_bmin, b_bsec, b_bv, b_nr};
        return {a_state, a_result, a_start, a_pause, a_stop, a_fmin, a_fsec,
                a_bmin, a_bsec, a_bv, a_nr};
    endfunction

    task automatic push_exp(input string tag);
        exp_t x;
        x.tag = tag;
        x.val = exp_vec();
        sb.push_back(x);
    endtask

    task automatic check(input bit use_b);
        exp_t x;
        logic [32:0] obs;
        x = sb.pop_front();
        obs = obs_vec(use_b);
        tests_run++;
        assert (obs === x.val) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.val);
        end
        $display("[TB] %s observed=%h expected=%h", x.tag, obs, x.val);
    endtask

    // Drive happens before the call; one clock edge samples it, outputs read on the negedge.
    task automatic step(input string tag, input bit use_b);
        push_exp(tag);
        @(posedge clk);
        @(negedge clk);
        check(use_b);
        game_start = 0; pause_req = 0; game_won = 0; abort = 0; clear_best = 0;
        e_cmd = 3'b000;
    endtask

    task automatic exp_start();
        e_state = 2'b01; e_result = 2'b00; e_cmd = 3'b100;
        e_fmin = 0; e_fsec = 0; e_nr = 0;
    endtask

    task automatic exp_finish(input logic [1:0] res);
        e_state = 2'b11; e_result = res; e_cmd = 3'b001;
        e_fmin = sw_min; e_fsec = sw_sec;
    endtask

    initial begin
        rst = 1; game_start = 0; pause_req = 0; game_won = 0; abort = 0; clear_best = 0;
        sw_min = 0; sw_sec = 0;
        e_state = 0; e_result = 0; e_cmd = 0; e_fmin = 0; e_fsec = 0;
        e_bmin = 0; e_bsec = 0; e_bv = 0; e_nr = 0;

        @(negedge clk);
        push_exp("reset");
        check(0);
        rst = 0;

        // Round 1: win at 01:23 becomes first record
        game_start = 1; exp_start(); step("t1_start", 0);
        step("t1_run0", 0);
        step("t1_run1", 0);
        sw_min = 1; sw_sec = 23; step("t1_run_0123", 0);
        game_won = 1; exp_finish(2'b01); e_bmin = 1; e_bsec = 23; e_bv = 1; e_nr = 1;
        step("t1_won", 0);
        game_won = 1; pause_req = 1; step("t1_finished_hold", 0);

        // Round 2: tie is not a record
        sw_min = 0; sw_sec = 0; game_start = 1; exp_start(); step("t2_start", 0);
        sw_min = 1; sw_sec = 23; step("t2_run", 0);
        game_won = 1; exp_finish(2'b01); step("t2_tie", 0);

        // Round 3: 01:10 beats 01:23
        sw_min = 0; sw_sec = 0; game_start = 1; exp_start(); step("t3r_start", 0);
        sw_min = 1; sw_sec = 10; game_won = 1; exp_finish(2'b01);
        e_bmin = 1; e_bsec = 10; e_nr = 1; step("t3r_record", 0);

        // Pause / resume / abort
        sw_min = 0; sw_sec = 20; game_start = 1; exp_start(); step("t4_start", 0);
        pause_req = 1; e_state = 2'b10; e_cmd = 3'b010; step("t4_pause", 0);
        game_won = 1; step("t4_won_ignored", 0);
        pause_req = 1; e_state = 2'b01; e_cmd = 3'b100; step("t4_resume", 0);
        sw_sec = 30; abort = 1; exp_finish(2'b11); step("t4_abort", 0);

        // abort beats game_won; clear_best with a win makes a fresh record
        sw_min = 0; sw_sec = 0; game_start = 1; exp_start(); step("t5_start", 0);
        sw_min = 2; sw_sec = 0; abort = 1; game_won = 1; exp_finish(2'b11);
        step("t5_abort_won", 0);
        game_start = 1; exp_start(); step("t5_start2", 0);
        sw_min = 2; sw_sec = 30; game_won = 1; clear_best = 1; exp_finish(2'b01);
        e_bmin = 2; e_bsec = 30; e_bv = 1; e_nr = 1; step("t5_clear_win", 0);
        clear_best = 1; e_bmin = 0; e_bsec = 0; e_bv = 0; step("t5_clear_finished", 0);

        // Async reset mid-round with a valid best
        sw_min = 0; sw_sec = 40; game_start = 1; exp_start(); step("t6_start", 0);
        game_won = 1; exp_finish(2'b01); e_bmin = 0; e_bsec = 40; e_bv = 1; e_nr = 1;
        step("t6_won", 0);
        game_start = 1; exp_start(); step("t6_start2", 0);
        #2 rst = 1;
        e_state = 0; e_result = 0; e_cmd = 0; e_fmin = 0; e_fsec = 0;
        e_bmin = 0; e_bsec = 0; e_bv = 0; e_nr = 0;
        #1 push_exp("t6_async_rst");
        check(0);
        @(negedge clk);
        push_exp("t6_rst_held");
        check(0);
        rst = 0;

        // Timeout with 5 s limit and stale stopwatch during holdoff
        sw_min = 0; sw_sec = 7; game_start = 1; exp_start(); step("t3_start", 1);
        step("t3_stale0", 1);
        step("t3_stale1", 1);
        sw_sec = 0; step("t3_sw0", 1);
        for (int s = 1; s < 5; s++) begin
            sw_sec = 6'(s); step("t3_count", 1);
        end
        sw_sec = 5; exp_finish(2'b10); step("t3_timeout", 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
